// File: rtl/apb4_prng_fifo.sv
// APB4 slave with a Galois LFSR feeding a small output FIFO of random words.
// Software seeds/enables the generator, pops values from VAL and watches STAT/irq_o.
module apb4_prng_fifo #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] POLY       = LFSR_WIDTH'(32'h04C1_1DB7),
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [5:0]            paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic                  en_q, en_d, ie_q, ie_d;
  logic [3:0]            skip_q, skip_d, skipCnt_q, skipCnt_d;
  logic [4:0]            thr_q, thr_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsrNext, seedVal;
  logic [AW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic       xfer, wrXfer, rdXfer, ctrlWr, seedWr, clr, valRd, pop, push, step;
  logic       empty, full;
  logic [3:0] idx;
  logic [4:0] countExt;
  logic [DATA_WIDTH-1:0] rdata;
  logic       unusedBits;

  assign idx      = paddr[5:2];
  assign xfer     = psel & penable;
  assign wrXfer   = xfer & pwrite;
  assign rdXfer   = xfer & ~pwrite;
  assign ctrlWr   = wrXfer & (idx == 4'd0);
  assign seedWr   = wrXfer & (idx == 4'd1);
  assign clr      = ctrlWr & pwdata[2];
  assign valRd    = rdXfer & (idx == 4'd2);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = valRd & ~empty;
  assign step     = en_q & ~full & ~seedWr;
  assign countExt = 5'(count_q);
  assign seedVal  = pwdata[LFSR_WIDTH-1:0];
  assign lfsrNext = {lfsr_q[LFSR_WIDTH-2:0], 1'b0} ^ (lfsr_q[LFSR_WIDTH-1] ? POLY : '0);
  assign unusedBits = ^{paddr[1:0], pwdata};

  always_comb begin
    en_d      = en_q;
    ie_d      = ie_q;
    skip_d    = skip_q;
    thr_d     = thr_q;
    lfsr_d    = lfsr_q;
    skipCnt_d = skipCnt_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    push      = 1'b0;

    if (ctrlWr) begin
      en_d   = pwdata[0];
      ie_d   = pwdata[1];
      skip_d = pwdata[7:4];
      thr_d  = pwdata[12:8];
    end

    // A seed load takes priority over stepping; a clear still lets the generator step but drops the value.
    if (seedWr) begin
      lfsr_d    = (seedVal == '0) ? LFSR_WIDTH'(1) : seedVal;
      skipCnt_d = 4'd0;
    end else if (step) begin
      lfsr_d = lfsrNext;
      if (skipCnt_q == skip_q) begin
        skipCnt_d = 4'd0;
        push      = ~clr;
      end else begin
        skipCnt_d = skipCnt_q + 4'd1;
      end
    end

    if (clr) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    irq_d = ie_q & (thr_q != 5'd0) & (countExt >= thr_q);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      skip_q    <= 4'd0;
      thr_q     <= 5'd0;
      lfsr_q    <= LFSR_WIDTH'(1);
      skipCnt_q <= 4'd0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      ie_q      <= ie_d;
      skip_q    <= skip_d;
      thr_q     <= thr_d;
      lfsr_q    <= lfsr_d;
      skipCnt_q <= skipCnt_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are valid.
  always_ff @(posedge pclk) begin
    if (push) mem_q[wrPtr_q] <= DATA_WIDTH'(lfsr_d);
  end

  always_comb begin
    rdata = '0;
    if (rdXfer) begin
      case (idx)
        4'd0: begin
          rdata[0]    = en_q;
          rdata[1]    = ie_q;
          rdata[7:4]  = skip_q;
          rdata[12:8] = thr_q;
        end
        4'd2: if (!empty) rdata = mem_q[rdPtr_q];
        4'd3: begin
          rdata[0]    = empty;
          rdata[1]    = full;
          rdata[12:8] = countExt;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign prdata  = presetn ? rdata : '0;
  assign pslverr = presetn & valRd & empty;
  assign pready  = 1'b1;
  assign irq_o   = irq_q;

endmodule

// File: doc/apb4_prng_fifo.md
APB4_PRNG_FIFO -- requirements
Module: apb4_prng_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width and FIFO entry width.
REQ-002 SHALL have parameter LFSR_WIDTH, default 32, LFSR state width, with 2 <= LFSR_WIDTH <= DATA_WIDTH.
REQ-003 SHALL have parameter POLY, default 32'h04C1_1DB7, LFSR_WIDTH-bit Galois feedback taps.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries; must be a power of 2, range 2..16.
REQ-005 SHALL have one clock and an asynchronous active-low reset: pclk in 1, APB clock; presetn in 1, asynchronous active-low reset.
REQ-006 SHALL have APB4 ports: paddr in 6, byte address; psel in 1; penable in 1; pwrite in 1; pwdata in DATA_WIDTH; prdata out DATA_WIDTH; pready out 1; pslverr out 1.
REQ-007 SHALL have port irq_o, out, 1, level interrupt.

Function
REQ-008 SHALL define a transfer as psel&penable; pready SHALL be constant 1, giving zero wait states.
REQ-009 SHALL decode register index paddr[5:2] as: 0 CTRL (RW), 1 SEED (W), 2 VAL (R, pops), 3 STAT (R).
REQ-010 SHALL lay out CTRL as: [0] EN, [1] IE, [2] CLR (write-1 pulse, reads 0), [7:4] SKIP, [12:8] THR; all other bits read 0.
REQ-011 SHALL lay out STAT as: [0] EMPTY, [1] FULL, [12:8] COUNT (0..FIFO_DEPTH); all other bits read 0.
REQ-012 SHALL drive prdata to 0 outside read transfers and for unmapped or write-only indices; writes to those indices SHALL be ignored.
REQ-013 SHALL advance the LFSR one step per cycle when EN=1, FIFO not full, and no SEED write occurs that cycle: next = {s[W-2:0],0} ^ (s[W-1] ? POLY : 0).
REQ-014 SHALL increment a 4-bit skip counter on each step; on the step where counter == SKIP it SHALL push the new state, zero-extended to DATA_WIDTH, and clear the counter.
REQ-015 SHALL push every step when SKIP=0; first push occurs one cycle after EN rises.
REQ-016 SHALL freeze the LFSR and skip counter when EN=0 or FULL=1; COUNT never exceeds FIFO_DEPTH.
REQ-017 SHALL, on a SEED write, load state = pwdata[LFSR_WIDTH-1:0] (or 1 if that value is 0) and clear the skip counter; there is no step and no push that cycle, and the FIFO is untouched.
REQ-018 SHALL, on a VAL read with FIFO non-empty, return the head entry combinationally and pop it at end of cycle with pslverr=0.
REQ-019 SHALL, on a VAL read with FIFO empty, return 0 with pslverr=1 and leave the state unchanged.
REQ-020 SHALL drive pslverr=0 for all other transfers.
REQ-021 SHALL handle a pop and push in the same cycle (not full): COUNT unchanged, entries stay in order.
REQ-022 SHALL block the push in the cycle a pop occurs while FULL=1; generation resumes next cycle.
REQ-023 SHALL, on a CTRL write with CLR=1, empty the FIFO and suppress any push that cycle; EN/IE/SKIP/THR are written from the same pwdata.
REQ-024 SHALL drive irq_o = IE & (THR != 0) & (COUNT >= THR), registered with 1-cycle latency from the COUNT change.

Reset
REQ-025 SHALL, on presetn low, asynchronously set: CTRL=0, LFSR state=1, skip counter=0, FIFO empty (COUNT=0, pointers 0), irq_o=0, prdata=0, pslverr=0.
REQ-026 SHALL discard FIFO contents and in-progress skip count on reset mid-operation; the first push after release with EN=1, SKIP=0 is value 2.

Verification
REQ-027 SHALL verify: SEED=1, CTRL=0x1 -> FIFO receives 0x2, 0x4, 0x8, ...; after 31 steps 0x80000000, next 0x04C11DB7.
REQ-028 SHALL verify: SEED=1, CTRL=0x31 (SKIP=3) -> first push 0x10, second push 0x100.
REQ-029 SHALL verify: EN=1 with no reads -> FULL=1, COUNT=8 after 8 cycles, LFSR frozen; one VAL read returns 0x2 and the next push is 0x200.
REQ-030 SHALL verify: VAL read on empty FIFO -> prdata=0, pslverr=1, STAT=0x1.
REQ-031 SHALL verify: CTRL=0x0403 (THR=4, IE, EN) -> irq_o rises the cycle after COUNT reaches 4; CTRL write 0x0407 (CLR) -> COUNT=0 and irq_o drops the next cycle.
REQ-032 SHALL verify: SEED write 0 -> state=1; SEED write in the same cycle as a would-be push -> no push that cycle, next push is the seed stepped once.
